// File: rtl/nn_inference_sequencer_if.sv
// Handshake and result bus between the inference sequencer, the network
// probability read port and the display logic.
interface nn_inference_sequencer_if #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned PROB_W = 16
);
    logic              Start;
    logic              Busy;
    logic              Nn_Compute;
    logic              Nn_Done;
    logic [IDX_W-1:0]  Prob_Index;
    logic [PROB_W-1:0] Prob_Data;
    logic              Result_Valid;
    logic [IDX_W-1:0]  Result_Class;
    logic [PROB_W-1:0] Result_Prob;
    logic              Timeout_Err;

    modport master (
        input  Start, Nn_Done, Prob_Data,
        output Busy, Nn_Compute, Prob_Index, Result_Valid, Result_Class,
               Result_Prob, Timeout_Err
    );

    modport slave (
        output Start, Nn_Done, Prob_Data,
        input  Busy, Nn_Compute, Prob_Index, Result_Valid, Result_Class,
               Result_Prob, Timeout_Err
    );
endinterface

// File: rtl/nn_inference_sequencer.sv
// Runs one neural_network inference: compute pulse, watchdog-guarded wait,
// indexed scan of class probabilities, and argmax result publication.
module nn_inference_sequencer #(
    parameter int unsigned N_CLASSES      = 10,
    parameter int unsigned PROB_W         = 16,
    parameter int unsigned IDX_W          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    nn_inference_sequencer_if.master bus
);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CLASSES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [2:0] {IDLE, PULSE, WAIT, SCAN, LAST, DONE} state_e;

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               compute_q, compute_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   cls_q, cls_d;
    logic [PROB_W-1:0]  prb_q, prb_d;
    logic [IDX_W-1:0]   best_cls_q, best_cls_d;
    logic [PROB_W-1:0]  best_prb_q, best_prb_d;
    logic               to_q, to_d;
    logic [WD_W-1:0]    wd_q, wd_d;

    // Next-state and next-output decode; every output is a registered copy.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        cls_d      = cls_q;
        prb_d      = prb_q;
        best_cls_d = best_cls_q;
        best_prb_d = best_prb_q;
        to_d       = to_q;
        wd_d       = wd_q;

        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d = PULSE;
                end
            end
            PULSE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Completion wins over an expiring watchdog in the same cycle.
                if (bus.Nn_Done) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end else if (wd_q == WD_LAST) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            SCAN: begin
                if (idx_q == IDX_LAST) begin
                    state_d = LAST;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
                // Prob_Data lags the index by one cycle: it belongs to idx_q-1.
                if (idx_q == IDX_ONE) begin
                    best_cls_d = '0;
                    best_prb_d = bus.Prob_Data;
                end else if (idx_q != '0 && bus.Prob_Data > best_prb_q) begin
                    best_cls_d = idx_q - IDX_ONE;
                    best_prb_d = bus.Prob_Data;
                end
            end
            LAST: begin
                state_d = DONE;
                if (bus.Prob_Data > best_prb_q) begin
                    best_cls_d = idx_q;
                    best_prb_d = bus.Prob_Data;
                end
            end
            DONE: begin
                if (bus.Start) begin
                    state_d = PULSE;
                end else begin
                    valid_d = 1'b1;
                    cls_d   = best_cls_q;
                    prb_d   = best_prb_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Entering PULSE starts a fresh run.
        if (state_d == PULSE) begin
            valid_d = 1'b0;
            to_d    = 1'b0;
            wd_d    = '0;
        end

        compute_d = (state_d == PULSE);
        busy_d    = (state_d == PULSE) || (state_d == WAIT) ||
                    (state_d == SCAN)  || (state_d == LAST);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            compute_q  <= 1'b0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            cls_q      <= '0;
            prb_q      <= '0;
            best_cls_q <= '0;
            best_prb_q <= '0;
            to_q       <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            compute_q  <= compute_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            cls_q      <= cls_d;
            prb_q      <= prb_d;
            best_cls_q <= best_cls_d;
            best_prb_q <= best_prb_d;
            to_q       <= to_d;
            wd_q       <= wd_d;
        end
    end

    assign bus.Busy         = busy_q;
    assign bus.Nn_Compute   = compute_q;
    assign bus.Prob_Index   = idx_q;
    assign bus.Result_Valid = valid_q;
    assign bus.Result_Class = cls_q;
    assign bus.Result_Prob  = prb_q;
    assign bus.Timeout_Err  = to_q;
endmodule
